conv_window_gen: RTL and testbench

Streaming 3x3 sliding-window generator for the Conv2D3x3 datapath. It accepts one pixel per cycle in raster order, buffers the previous two image rows, and emits each full 3x3 neighbourhood as a packed 9-term vector. It sits directly upstream of the MulDSP/TreeAdder pair and replaces the ad-hoc shift register that feeds MulDSP's `i_terms_a` today. Convolution is "valid" style: no padding, so the block emits (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.

---
 rtl/conv_window_gen.sv | 126 ++++++++++++
 tb/tb_conv_window_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator.
// Accepts one pixel per cycle in raster order, keeps the two previous rows in
// line buffers and emits every complete 3x3 neighbourhood ("valid" convolution,
// no padding) as a packed 9-term vector with a valid/ready output handshake.
//
// Handshake: a pixel transfers on a rising edge where i_valid && o_ready; a
// window transfers on a rising edge where o_valid && i_ready. o_ready is
// !o_valid || i_ready, so an accept never overwrites an unconsumed window, and
// while o_valid && !i_ready every piece of state holds.
module conv_window_gen #(
    parameter int WORD_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [WORD_WIDTH-1:0]     i_pixel,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [9*WORD_WIDTH-1:0]   o_window,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [WORD_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [WORD_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [WORD_WIDTH-1:0] win      [9];
    logic [WORD_WIDTH-1:0] win_next [9];
    logic [9*WORD_WIDTH-1:0] win_packed;
    logic accept;
    logic emit;
    logic frame_end;

    assign o_ready   = !o_valid || i_ready;
    assign accept    = i_valid && o_ready;
    // The pixel being accepted completes a window once two full rows and two
    // earlier columns of the current row are already behind it.
    assign emit      = (row >= ROW_TWO) && (col >= COL_TWO);
    assign frame_end = (row == ROW_MAX) && (col == COL_MAX);

    // Window after the shift: columns move left, the buffered column enters c=2.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_next[r*3+0] = win[r*3+1];
            win_next[r*3+1] = win[r*3+2];
        end
        win_next[2] = lb0[col];
        win_next[5] = lb1[col];
        win_next[8] = i_pixel;
    end

    // Pack the shifted window, term k at [k*WORD_WIDTH +: WORD_WIDTH].
    always_comb begin
        win_packed = '0;
        for (int k = 0; k < 9; k++) begin
            win_packed[k*WORD_WIDTH +: WORD_WIDTH] = win_next[k];
        end
    end

    // Raster position counters; wrap at end of row and end of frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers: row-above moves up, new pixel replaces it. Never reset;
    // stale contents are only read while emission is still gated off.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= i_pixel;
        end
    end

    // 3x3 working window, shifted on every accepted pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= win_next[k];
            end
        end
    end

    // Output register: load on an emitting accept, clear valid on a
    // non-emitting accept or on a drain, hold during a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_window <= '0;
        end else if (accept) begin
            o_valid <= emit;
            o_last  <= emit && frame_end;
            if (emit) begin
                o_window <= win_packed;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 instance for the directed scenarios and a
// default 32x32 instance for a random frame. Expected windows come from a
// frame-level model that cuts every 3x3 neighbourhood out of a pixel array.
module tb_conv_window_gen;

    localparam int W   = 8;
    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int LW  = 32;
    localparam int LH  = 32;
    localparam int WIN = 9 * W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // small (4x4) instance signals
    logic [W-1:0]   s_pixel;
    logic           s_valid;
    logic           s_ready_in;
    logic           s_o_ready;
    logic           s_o_valid;
    logic           s_o_last;
    logic [WIN-1:0] s_window;

    // large (32x32) instance signals
    logic [W-1:0]   l_pixel;
    logic           l_valid;
    logic           l_ready_in;
    logic           l_o_ready;
    logic           l_o_valid;
    logic           l_o_last;
    logic [WIN-1:0] l_window;

    conv_window_gen #(.WORD_WIDTH(W), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pixel  (s_pixel),
        .i_valid  (s_valid),
        .o_ready  (s_o_ready),
        .o_window (s_window),
        .o_valid  (s_o_valid),
        .i_ready  (s_ready_in),
        .o_last   (s_o_last)
    );

    conv_window_gen dut_l (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pixel  (l_pixel),
        .i_valid  (l_valid),
        .o_ready  (l_o_ready),
        .o_window (l_window),
        .o_valid  (l_o_valid),
        .i_ready  (l_ready_in),
        .o_last   (l_o_last)
    );

    int checks   = 0;
    int failures = 0;

    // scoreboard: {last, window} per expected window, and pixels to send
    logic [WIN:0] exp_s[$];
    logic [WIN:0] exp_l[$];
    logic [W-1:0] pix_q[$];
    logic [W-1:0] img [LH][LW];

    int win_cnt_s, last_cnt_s, win_cnt_l, last_cnt_l;
    int n_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit big, input logic v, input logic [W-1:0] p, input logic r);
        if (big) begin
            l_valid = v; l_pixel = p; l_ready_in = r;
        end else begin
            s_valid = v; s_pixel = p; s_ready_in = r;
        end
    endtask

    function automatic logic dut_ready(input bit big);
        return big ? l_o_ready : s_o_ready;
    endfunction

    function automatic logic dut_valid(input bit big);
        return big ? l_o_valid : s_o_valid;
    endfunction

    function automatic logic [WIN-1:0] dut_window(input bit big);
        return big ? l_window : s_window;
    endfunction

    function automatic int exp_size(input bit big);
        return big ? exp_l.size() : exp_s.size();
    endfunction

    task automatic clear_counts();
        win_cnt_s = 0; last_cnt_s = 0; win_cnt_l = 0; last_cnt_l = 0;
    endtask

    // Basic 4x4 frame p = r*4 + c + 1 + off.
    task automatic set_basic(input int off);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                img[r][c] = W'(r * SW + c + 1 + off);
    endtask

    // Reference model: queue the frame's pixels and every valid-mode 3x3
    // neighbourhood in raster order, last flag on the bottom-right one.
    task automatic load_frame(input bit big);
        int h = big ? LH : SH;
        int w = big ? LW : SW;
        logic [WIN-1:0] wv;
        logic lst;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix_q.push_back(img[r][c]);
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                for (int k = 0; k < 9; k++)
                    wv[k*W +: W] = img[r-2+k/3][c-2+k%3];
                lst = (r == h - 1) && (c == w - 1);
                if (big) exp_l.push_back({lst, wv});
                else     exp_s.push_back({lst, wv});
            end
        end
    endtask

    // Send pix_q and drain all expected windows. vpct/rpct are the per-cycle
    // probabilities of i_valid/i_ready; stall_req forces i_ready low for that
    // many cycles from the first window; first_acc > 0 checks how many pixels
    // were accepted when the first window shows up.
    task automatic stream(input bit big, input int vpct, input int rpct,
                          input int stall_req, input int first_acc);
        int budget = 20000;
        bit seen = 0;
        int stall_left = 0;
        int acc_at_stall = 0;
        logic v, rdy;
        logic [WIN:0] front;
        n_acc = 0;
        while ((pix_q.size() > 0 || exp_size(big) > 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (dut_valid(big) && !seen) begin
                seen = 1;
                if (first_acc > 0) chk("first_window_latency", n_acc, first_acc);
                if (stall_req > 0) begin
                    stall_left = stall_req;
                    acc_at_stall = n_acc;
                end
            end
            v   = (pix_q.size() > 0) && ($urandom_range(99) < vpct);
            rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
            drive(big, v, v ? pix_q[0] : '0, rdy);
            @(negedge clk);
            if (stall_left > 0) begin
                front = big ? exp_l[0] : exp_s[0];
                chk("stall_o_ready", dut_ready(big), 1'b0);
                chk("stall_window_hold", dut_window(big), front[WIN-1:0]);
                chk("stall_no_accept", n_acc, acc_at_stall);
                stall_left--;
            end
            if (v && dut_ready(big)) begin
                void'(pix_q.pop_front());
                n_acc++;
            end
        end
        chk("stream_budget_expired", budget == 0, 1'b0);
        @(posedge clk); #1;
        drive(big, 1'b0, '0, 1'b1);
    endtask

    // Window monitors: a transfer is o_valid && i_ready at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("s_last_without_valid", s_o_last && !s_o_valid, 1'b0);
            if (s_o_valid && s_ready_in) begin
                win_cnt_s++;
                if (s_o_last) last_cnt_s++;
                if (exp_s.size() == 0) chk("s_unexpected_window", exp_s.size(), 1);
                else chk("s_window", {s_o_last, s_window}, exp_s.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("l_last_without_valid", l_o_last && !l_o_valid, 1'b0);
            if (l_o_valid && l_ready_in) begin
                win_cnt_l++;
                if (l_o_last) last_cnt_l++;
                if (exp_l.size() == 0) chk("l_unexpected_window", exp_l.size(), 1);
                else chk("l_window", {l_o_last, l_window}, exp_l.pop_front());
            end
        end
    end

    initial begin
        int k;
        int budget;
        rst_n = 1'b1;
        drive(0, 1'b0, '0, 1'b1);
        drive(1, 1'b0, '0, 1'b1);
        clear_counts();

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_valid", s_o_valid, 1'b0);
        chk("rst_s_last", s_o_last, 1'b0);
        chk("rst_s_window", s_window, '0);
        chk("rst_s_ready", s_o_ready, 1'b1);
        chk("rst_l_valid", l_o_valid, 1'b0);
        chk("rst_l_window", l_window, '0);
        chk("rst_l_ready", l_o_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic 4x4 frame, full throughput
        set_basic(0);
        load_frame(0);
        stream(0, 100, 100, 0, 11);
        chk("basic_count", win_cnt_s, 4);
        chk("basic_last_count", last_cnt_s, 1);

        // backpressure on the first window
        clear_counts();
        load_frame(0);
        stream(0, 100, 100, 3, 11);
        chk("bp_count", win_cnt_s, 4);

        // input gaps
        clear_counts();
        load_frame(0);
        stream(0, 50, 100, 0, 11);
        chk("gaps_count", win_cnt_s, 4);

        // random gaps and random backpressure
        clear_counts();
        load_frame(0);
        stream(0, 60, 60, 0, 11);
        chk("rand_bp_count", win_cnt_s, 4);

        // back-to-back frames, second offset by 100
        clear_counts();
        set_basic(0);
        load_frame(0);
        set_basic(100);
        load_frame(0);
        stream(0, 100, 100, 0, 11);
        chk("b2b_count", win_cnt_s, 8);
        chk("b2b_last_count", last_cnt_s, 2);

        // reset with a pending window: feed 11 pixels with i_ready low
        set_basic(0);
        k = 0;
        budget = 100;
        while (k < 11 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            drive(0, 1'b1, img[k/SW][k%SW], 1'b0);
            @(negedge clk);
            if (s_o_ready) k++;
        end
        chk("partial_feed_count", k, 11);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0);
        chk("pending_window_valid", s_o_valid, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", s_o_valid, 1'b0);
        chk("midrst_window", s_window, '0);
        chk("midrst_last", s_o_last, 1'b0);
        chk("midrst_ready", s_o_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, '0, 1'b1);
        clear_counts();
        load_frame(0);
        stream(0, 100, 100, 0, 11);
        chk("after_rst_count", win_cnt_s, 4);
        chk("after_rst_last_count", last_cnt_s, 1);

        // default 32x32 random frame
        clear_counts();
        for (int r = 0; r < LH; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = W'($urandom_range(255));
        load_frame(1);
        stream(1, 70, 80, 0, 2 * LW + 3);
        chk("large_count", win_cnt_l, 900);
        chk("large_last_count", last_cnt_l, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
